// File: rtl/mem_stack_responder_pkg.sv
// Shared definitions for the memory/stack responder.
// The load-source encodings are the same ones the control path's load mux
// decodes, so both sides agree on which requests need a read.
// No ports: package only.
package mem_stack_responder_pkg;

  // Load-source encodings; bit 1 set means the value comes from a RAM bank.
  localparam logic [1:0] LD_SELF = 2'b00;
  localparam logic [1:0] LD_ALU  = 2'b01;
  localparam logic [1:0] LD_MEM  = 2'b10;
  localparam logic [1:0] LD_STK  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR      = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // True when any address bit at or above position aw is set, i.e. the
  // address does not fit the target bank and will be truncated.
  function automatic logic addr_overflow(input logic [31:0] addr, input int unsigned aw);
    return (addr >> aw) != 32'd0;
  endfunction

endpackage

// File: rtl/mem_stack_responder_bank_port.sv
// One RAM bank interface: truncates the request address to the bank width,
// flags overflow, and registers the address, write data and write enable
// that drive the synchronous single-port RAM.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   load          capture addr_in/wdata_in this cycle (request accepted)
//   addr_in       full-width request address
//   wdata_in      store data
//   we_next       write enable for the next cycle
//   addr          registered bank address (holds when not loaded)
//   wdata         registered bank write data
//   we            registered bank write enable
//   ovf           combinational: addr_in has bits set above the bank width
module mem_stack_responder_bank_port
  import mem_stack_responder_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int AW     = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              we_next,
  output logic [AW-1:0]     addr,
  output logic [DATA_W-1:0] wdata,
  output logic              we,
  output logic              ovf
);

  assign ovf = addr_overflow(32'(addr_in), AW);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr  <= '0;
      wdata <= '0;
      we    <= 1'b0;
    end else begin
      we <= we_next;
      if (load) begin
        addr  <= addr_in[AW-1:0];
        wdata <= wdata_in;
      end
    end
  end

endmodule

// File: rtl/mem_stack_responder.sv
// Responder for the control path's load/store protocol. Accepts one request
// at a time, reads the main-memory or stack bank if the load source needs it,
// performs any stores afterwards (so a read of the same location returns the
// old value), then pulses resp_valid. All outputs are registered.
// Ports:
//   clock, reset                   system clock, synchronous active-high reset
//   req_valid/req_ready            request handshake (accepted when both high)
//   req_load_src                   00 self, 01 alu, 10 mem, 11 stk
//   req_store_mem/req_store_stk    store req_wdata to the named bank
//   req_addr/req_wdata             address (ALU result) and store data
//   resp_valid                     one-cycle completion pulse
//   resp_rdata                     last read data, held between reads
//   resp_addr_err                  address overflowed an accessed bank
//   mem_*/stk_*                    synchronous single-port RAM interfaces
module mem_stack_responder
  import mem_stack_responder_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int MEM_AW       = 12,
  parameter int STK_AW       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [1:0]        req_load_src,
  input  logic              req_store_mem,
  input  logic              req_store_stk,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_addr_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STK_AW-1:0] stk_addr,
  output logic [DATA_W-1:0] stk_wdata,
  output logic              stk_we,
  input  logic [DATA_W-1:0] stk_rdata
);

  state_t     state, state_next;
  logic [1:0] rd_cnt;
  logic       cap_rd_stk, cap_st_mem, cap_st_stk, cap_noop, cap_err;

  logic accept, read_done, resp_next;
  logic use_mem, use_stk, mem_ovf, stk_ovf;
  logic st_mem_eff, st_stk_eff;

  assign accept  = req_valid && req_ready;
  assign use_mem = (req_load_src == LD_MEM) || req_store_mem;
  assign use_stk = (req_load_src == LD_STK) || req_store_stk;

  // The bank address is first presented in the cycle after accept, and the
  // RAM needs READ_LATENCY more cycles before its rdata reflects it.
  assign read_done = (state == ST_RD_WAIT) && (rd_cnt == 2'(READ_LATENCY));

  // Entering WR straight from IDLE uses the live request; otherwise the
  // captured copy.
  assign st_mem_eff = (state == ST_IDLE) ? req_store_mem : cap_st_mem;
  assign st_stk_eff = (state == ST_IDLE) ? req_store_stk : cap_st_stk;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    resp_next  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_load_src[1])                     state_next = ST_RD_WAIT;
          else if (req_store_mem || req_store_stk) state_next = ST_WR;
          else                                     state_next = ST_DONE;
        end
      end
      ST_RD_WAIT: if (read_done) state_next = (cap_st_mem || cap_st_stk) ? ST_WR : ST_DONE;
      ST_WR:      state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    // Worked requests pulse while in DONE. A bare request has nothing to wait
    // on, so its pulse lands the cycle after DONE, two cycles after accept.
    resp_next = ((state_next == ST_DONE) && (state != ST_IDLE)) ||
                ((state == ST_DONE) && cap_noop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_addr_err <= 1'b0;
      rd_cnt        <= '0;
      cap_rd_stk    <= 1'b0;
      cap_st_mem    <= 1'b0;
      cap_st_stk    <= 1'b0;
      cap_noop      <= 1'b0;
      cap_err       <= 1'b0;
    end else begin
      state         <= state_next;
      req_ready     <= (state_next == ST_IDLE);
      resp_valid    <= resp_next;
      resp_addr_err <= resp_next && cap_err;
      if (accept) begin
        rd_cnt     <= '0;
        cap_rd_stk <= (req_load_src == LD_STK);
        cap_st_mem <= req_store_mem;
        cap_st_stk <= req_store_stk;
        cap_noop   <= !req_load_src[1] && !req_store_mem && !req_store_stk;
        cap_err    <= (use_mem && mem_ovf) || (use_stk && stk_ovf);
      end else if (state == ST_RD_WAIT) begin
        rd_cnt <= rd_cnt + 2'd1;
      end
      if (read_done) resp_rdata <= cap_rd_stk ? stk_rdata : mem_rdata;
    end
  end

  mem_stack_responder_bank_port #(.DATA_W(DATA_W), .AW(MEM_AW)) u_mem_port (
    .clock    (clock),
    .reset    (reset),
    .load     (accept && use_mem),
    .addr_in  (req_addr),
    .wdata_in (req_wdata),
    .we_next  ((state_next == ST_WR) && st_mem_eff),
    .addr     (mem_addr),
    .wdata    (mem_wdata),
    .we       (mem_we),
    .ovf      (mem_ovf)
  );

  mem_stack_responder_bank_port #(.DATA_W(DATA_W), .AW(STK_AW)) u_stk_port (
    .clock    (clock),
    .reset    (reset),
    .load     (accept && use_stk),
    .addr_in  (req_addr),
    .wdata_in (req_wdata),
    .we_next  ((state_next == ST_WR) && st_stk_eff),
    .addr     (stk_addr),
    .wdata    (stk_wdata),
    .we       (stk_we),
    .ovf      (stk_ovf)
  );

endmodule

// File: tb/tb_mem_stack_responder.sv
// Scoreboard bench for mem_stack_responder with READ_LATENCY=2 and
// behavioural synchronous RAMs on both bank ports.
module tb_mem_stack_responder;

  localparam int DATA_W = 16;
  localparam int MEM_AW = 12;
  localparam int STK_AW = 8;
  localparam int L      = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic [1:0]        req_load_src = 2'b00;
  logic              req_store_mem = 1'b0;
  logic              req_store_stk = 1'b0;
  logic [DATA_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              req_ready, resp_valid, resp_addr_err;
  logic [DATA_W-1:0] resp_rdata;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_we;
  logic [STK_AW-1:0] stk_addr;
  logic [DATA_W-1:0] stk_wdata, stk_rdata;
  logic              stk_we;

  mem_stack_responder #(
    .DATA_W(DATA_W), .MEM_AW(MEM_AW), .STK_AW(STK_AW), .READ_LATENCY(L)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_load_src  (req_load_src),
    .req_store_mem (req_store_mem),
    .req_store_stk (req_store_stk),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_addr_err (resp_addr_err),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_rdata     (mem_rdata),
    .stk_addr      (stk_addr),
    .stk_wdata     (stk_wdata),
    .stk_we        (stk_we),
    .stk_rdata     (stk_rdata)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous RAMs: address registered at the edge, data valid L cycles
  // after the address is first presented; read-before-write on collision.
  logic [DATA_W-1:0] mem_ram [1 << MEM_AW];
  logic [DATA_W-1:0] stk_ram [1 << STK_AW];
  logic [DATA_W-1:0] mem_pipe [L];
  logic [DATA_W-1:0] stk_pipe [L];

  always @(posedge clock) begin
    if (mem_we) mem_ram[mem_addr] <= mem_wdata;
    if (stk_we) stk_ram[stk_addr] <= stk_wdata;
    mem_pipe[0] <= mem_ram[mem_addr];
    stk_pipe[0] <= stk_ram[stk_addr];
    for (int i = 1; i < L; i++) begin
      mem_pipe[i] <= mem_pipe[i-1];
      stk_pipe[i] <= stk_pipe[i-1];
    end
  end
  assign mem_rdata = mem_pipe[L-1];
  assign stk_rdata = stk_pipe[L-1];

  // Scoreboard
  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          cyc;
    int          bank;   // 0: no address check, 1: mem, 2: stk
    logic [15:0] baddr;
  } resp_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  resp_t rq[$];
  wr_t   mq[$];
  wr_t   sq[$];

  logic [15:0] mem_model [1 << MEM_AW];
  logic [15:0] stk_model [1 << STK_AW];
  logic [15:0] last_rdata = 16'h0000;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a response or write.
  always @(negedge clock) begin
    if (!reset) begin
      if (resp_valid) begin : mon_resp
        resp_t e;
        check("resp_expected", 32'(rq.size() != 0), 32'd1);
        if (rq.size() != 0) begin
          e = rq.pop_front();
          check("resp_cycle", 32'(cyc), 32'(e.cyc));
          check("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
          check("resp_addr_err", 32'(resp_addr_err), 32'(e.err));
          if (e.bank == 1) check("resp_mem_addr", 32'(mem_addr), 32'(e.baddr[11:0]));
          if (e.bank == 2) check("resp_stk_addr", 32'(stk_addr), 32'(e.baddr[7:0]));
        end
      end
      if (mem_we) begin : mon_mem
        wr_t w;
        check("mem_we_expected", 32'(mq.size() != 0), 32'd1);
        if (mq.size() != 0) begin
          w = mq.pop_front();
          check("mem_we_cycle", 32'(cyc), 32'(w.cyc));
          check("mem_we_addr", 32'(mem_addr), 32'(w.addr));
          check("mem_we_data", 32'(mem_wdata), 32'(w.data));
        end
      end
      if (stk_we) begin : mon_stk
        wr_t w;
        check("stk_we_expected", 32'(sq.size() != 0), 32'd1);
        if (sq.size() != 0) begin
          w = sq.pop_front();
          check("stk_we_cycle", 32'(cyc), 32'(w.cyc));
          check("stk_we_addr", 32'(stk_addr), 32'(w.addr));
          check("stk_we_data", 32'(stk_wdata), 32'(w.data));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Call just after a negedge. Presents the request, waits (bounded) for
  // req_ready, pushes the expected writes/response, returns at the negedge of
  // cycle N+1. With hold set, req_valid stays high for a following request.
  task automatic issue(input logic [1:0] src, input logic st_m, input logic st_s,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input bit hold, input bit exp_resp);
    int    n;
    logic  rd, rs, err;
    resp_t r;
    wr_t   w;
    req_load_src  = src;
    req_store_mem = st_m;
    req_store_stk = st_s;
    req_addr      = addr;
    req_wdata     = wdata;
    req_valid     = 1'b1;
    for (int k = 0; k < 40 && !req_ready; k++) @(negedge clock);
    check("accept_ready", 32'(req_ready), 32'd1);
    n   = cyc;
    rd  = src[1];
    rs  = (src == 2'b11);
    err = (((rd && !rs) || st_m) && (addr[15:12] != 4'h0)) ||
          ((rs || st_s) && (addr[15:8] != 8'h00));
    if (exp_resp) begin
      if (rd) last_rdata = rs ? stk_model[addr[7:0]] : mem_model[addr[11:0]];
      r.rdata = last_rdata;
      r.err   = err;
      r.cyc   = rd ? ((st_m || st_s) ? n + L + 3 : n + L + 2) : n + 2;
      r.bank  = rd ? (rs ? 2 : 1) : 0;
      r.baddr = addr;
      rq.push_back(r);
      w.cyc  = rd ? n + L + 2 : n + 1;
      w.data = wdata;
      if (st_m) begin
        w.addr = {4'h0, addr[11:0]};
        mq.push_back(w);
        mem_model[addr[11:0]] = wdata;
      end
      if (st_s) begin
        w.addr = {8'h00, addr[7:0]};
        sq.push_back(w);
        stk_model[addr[7:0]] = wdata;
      end
    end
    @(negedge clock);
    if (!hold) req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << MEM_AW); i++) begin
      mem_ram[i] = 16'h0000;
      mem_model[i] = 16'h0000;
    end
    for (int i = 0; i < (1 << STK_AW); i++) begin
      stk_ram[i] = 16'h0000;
      stk_model[i] = 16'h0000;
    end
    stk_ram[8'h05]    = 16'h1234;
    stk_model[8'h05]  = 16'h1234;
    mem_ram[12'h100]   = 16'hA5A5;
    mem_model[12'h100] = 16'hA5A5;

    // Reset state
    reset = 1'b1;
    idle(3);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check("rst_addr_err", 32'(resp_addr_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_stk_we", 32'(stk_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_stk_addr", 32'(stk_addr), 32'd0);
    reset = 1'b0;
    idle(1);

    // No-op: ready low for exactly one cycle, response at N+2
    issue(2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    check("noop_ready_busy", 32'(req_ready), 32'd0);
    idle(1);
    check("noop_ready_back", 32'(req_ready), 32'd1);
    idle(3);

    // Store-only to mem
    issue(2'b00, 1'b1, 1'b0, 16'h0012, 16'hBEEF, 1'b0, 1'b1);
    idle(4);
    // Read it back
    issue(2'b10, 1'b0, 1'b0, 16'h0012, 16'h0000, 1'b0, 1'b1);
    idle(6);
    // Read + store same stack location: old value returned, write follows
    issue(2'b11, 1'b0, 1'b1, 16'h0005, 16'h5678, 1'b0, 1'b1);
    idle(7);
    issue(2'b11, 1'b0, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b1);
    idle(6);
    // Address overflow on mem read, access proceeds truncated
    issue(2'b10, 1'b0, 1'b0, 16'h1100, 16'h0000, 1'b0, 1'b1);
    idle(6);
    // ALU source with stores to both banks in the same cycle
    issue(2'b01, 1'b1, 1'b1, 16'h0033, 16'h1111, 1'b0, 1'b1);
    idle(4);
    // Stack store overflowing the 8-bit stack address
    issue(2'b00, 1'b0, 1'b1, 16'h0120, 16'h2222, 1'b0, 1'b1);
    idle(4);

    // Reset during RD_WAIT: read dropped, no response
    issue(2'b10, 1'b0, 1'b0, 16'h0012, 16'h0000, 1'b0, 1'b0);
    reset = 1'b1;
    idle(1);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_resp_rdata", 32'(resp_rdata), 32'd0);
    check("midrst_mem_we", 32'(mem_we), 32'd0);
    check("midrst_stk_we", 32'(stk_we), 32'd0);
    reset = 1'b0;
    last_rdata = 16'h0000;
    idle(6);

    // Back-to-back with req_valid held: store, read of the same word, no-op
    issue(2'b00, 1'b1, 1'b0, 16'h0040, 16'h0001, 1'b1, 1'b1);
    issue(2'b10, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b1);
    issue(2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

    for (int k = 0; k < 100 && (rq.size() != 0 || mq.size() != 0 || sq.size() != 0); k++)
      @(negedge clock);
    idle(5);
    check("drain_resp", 32'(rq.size()), 32'd0);
    check("drain_mem_wr", 32'(mq.size()), 32'd0);
    check("drain_stk_wr", 32'(sq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
